// File: rtl/mcpu_sim_sequencer.sv
// Run controller for TB_MCPU_core: stretches core reset, runs the core for a bounded
// number of cycles, drives meminput from programmable channels and logs memoutput changes.
module mcpu_sim_sequencer #(
    parameter int DATA_W    = 32,
    parameter int NUM_IN    = 4,
    parameter int RESET_CYC = 5,
    parameter int MAX_CYC   = 200,
    parameter int CYC_W     = 16,
    parameter int LOG_DEPTH = 8,
    localparam int SEL_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clkrst_core_clk,
    input  logic                     clkrst_core_rst_n,
    output logic                     core_rst_n,
    input  logic [DATA_W-1:0]        core_memoutput,
    output logic [DATA_W-1:0]        core_meminput,
    input  logic                     cfg_we,
    input  logic [SEL_W-1:0]         cfg_addr,
    input  logic [DATA_W-1:0]        cfg_wdata,
    input  logic [SEL_W-1:0]         cfg_sel,
    input  logic                     restart,
    output logic                     log_valid,
    input  logic                     log_ready,
    output logic [CYC_W+DATA_W-1:0]  log_data,
    output logic                     log_overflow,
    output logic [CYC_W-1:0]         run_cycle,
    output logic [1:0]               state,
    output logic                     done
);

    localparam int PTR_W  = $clog2(LOG_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = $clog2(RESET_CYC + 1);
    localparam int LOG_W  = CYC_W + DATA_W;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYC - 1);
    localparam logic [CYC_W-1:0]  RUN_LAST  = CYC_W'(MAX_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(LOG_DEPTH);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    seq_state_e          state_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [CYC_W-1:0]    run_cycle_r;
    logic                core_rst_n_r;
    logic                done_r;

    logic [DATA_W-1:0]   chan_r [NUM_IN];
    logic [DATA_W-1:0]   prev_r;

    logic [LOG_W-1:0]    mem_r [LOG_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                overflow_r;

    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                wr_en_s;

    // Sequencer FSM: HOLD (core in reset) -> RUN (bounded) -> DONE (frozen until restart)
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_r      <= ST_HOLD;
            hold_cnt_r   <= '0;
            run_cycle_r  <= '0;
            core_rst_n_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r      <= ST_RUN;
                        hold_cnt_r   <= '0;
                        run_cycle_r  <= '0;
                        core_rst_n_r <= 1'b1;
                    end else begin
                        hold_cnt_r   <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (run_cycle_r == RUN_LAST) begin
                        state_r      <= ST_DONE;
                        core_rst_n_r <= 1'b0;
                        done_r       <= 1'b1;
                    end else begin
                        run_cycle_r  <= run_cycle_r + CYC_W'(1);
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        state_r     <= ST_HOLD;
                        hold_cnt_r  <= '0;
                        run_cycle_r <= '0;
                        done_r      <= 1'b0;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r      <= ST_HOLD;
                    hold_cnt_r   <= '0;
                    run_cycle_r  <= '0;
                    core_rst_n_r <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    // Programmable meminput channel registers
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                chan_r[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_addr) < NUM_IN)) begin
            chan_r[cfg_addr] <= cfg_wdata;
        end
    end

    // Channel mux toward the core; unmapped selects read as zero
    always_comb begin
        core_meminput = '0;
        if (int'(cfg_sel) < NUM_IN) begin
            core_meminput = chan_r[cfg_sel];
        end else begin
            core_meminput = '0;
        end
    end

    // Previous memoutput sample, only tracked while the core is running
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            prev_r <= '0;
        end else if (state_r == ST_RUN) begin
            prev_r <= core_memoutput;
        end
    end

    // Log request: first RUN cycle always logs so each run has a baseline entry
    always_comb begin
        push_s = 1'b0;
        if (state_r == ST_RUN) begin
            if ((run_cycle_r == '0) || (core_memoutput != prev_r)) begin
                push_s = 1'b1;
            end else begin
                push_s = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    assign pop_s   = (count_r != '0) && log_ready;
    assign full_s  = (count_r == CNT_FULL);
    assign wr_en_s = push_s && (!full_s || pop_s);

    // Log storage; a concurrent pop frees the slot a full-FIFO push lands in
    always_ff @(posedge clkrst_core_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {run_cycle_r, core_memoutput};
        end
    end

    // Log FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (push_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign core_rst_n   = core_rst_n_r;
    assign done         = done_r;
    assign run_cycle    = run_cycle_r;
    assign state        = state_r;
    assign log_valid    = (count_r != '0);
    assign log_data     = mem_r[rd_ptr_r];
    assign log_overflow = overflow_r;

endmodule

// File: tb/tb_mcpu_sim_sequencer.sv
// Self-checking bench for mcpu_sim_sequencer: directed tables and sequences plus
// randomized traffic against an edge-count based reference model.
module tb_mcpu_sim_sequencer;

    localparam int DATA_W    = 32;
    localparam int NUM_IN    = 4;
    localparam int RESET_CYC = 5;
    localparam int MAX_CYC   = 200;
    localparam int CYC_W     = 16;
    localparam int LOG_DEPTH = 8;
    localparam int SEL_W     = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    core_rst_n;
    logic [DATA_W-1:0]       core_memoutput;
    logic [DATA_W-1:0]       core_meminput;
    logic                    cfg_we;
    logic [SEL_W-1:0]        cfg_addr;
    logic [DATA_W-1:0]       cfg_wdata;
    logic [SEL_W-1:0]        cfg_sel;
    logic                    restart;
    logic                    log_valid;
    logic                    log_ready;
    logic [CYC_W+DATA_W-1:0] log_data;
    logic                    log_overflow;
    logic [CYC_W-1:0]        run_cycle;
    logic [1:0]              state;
    logic                    done;

    mcpu_sim_sequencer #(
        .DATA_W(DATA_W), .NUM_IN(NUM_IN), .RESET_CYC(RESET_CYC),
        .MAX_CYC(MAX_CYC), .CYC_W(CYC_W), .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .core_rst_n        (core_rst_n),
        .core_memoutput    (core_memoutput),
        .core_meminput     (core_meminput),
        .cfg_we            (cfg_we),
        .cfg_addr          (cfg_addr),
        .cfg_wdata         (cfg_wdata),
        .cfg_sel           (cfg_sel),
        .restart           (restart),
        .log_valid         (log_valid),
        .log_ready         (log_ready),
        .log_data          (log_data),
        .log_overflow      (log_overflow),
        .run_cycle         (run_cycle),
        .state             (state),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: k = clock edges since the latest HOLD entry
    int                      k;
    logic [DATA_W-1:0]       m_prev;
    logic [CYC_W+DATA_W-1:0] m_q[$];
    bit                      m_ovf;
    logic [DATA_W-1:0]       m_ch[NUM_IN];

    typedef struct {
        bit                 we;
        logic [SEL_W-1:0]   addr;
        logic [DATA_W-1:0]  wdata;
        logic [SEL_W-1:0]   sel;
        logic [DATA_W-1:0]  exp_in;
    } cfg_vec_t;

    cfg_vec_t cfg_tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_phase();
        if (k < RESET_CYC) return 0;
        else if (k < RESET_CYC + MAX_CYC) return 1;
        else return 2;
    endfunction

    task automatic model_reset();
        k = 0;
        m_prev = '0;
        m_q.delete();
        m_ovf = 1'b0;
        for (int i = 0; i < NUM_IN; i++) m_ch[i] = '0;
    endtask

    task automatic check_outputs();
        int ph;
        ph = m_phase();
        chk("state", 64'(state), 64'(ph));
        chk("core_rst_n", 64'(core_rst_n), 64'(ph == 1));
        chk("done", 64'(done), 64'(ph == 2));
        if (ph == 0) chk("run_cycle_hold", 64'(run_cycle), 64'd0);
        else if (ph == 1) chk("run_cycle", 64'(run_cycle), 64'(k - RESET_CYC));
        chk("log_valid", 64'(log_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk("log_data", 64'(log_data), 64'(m_q[0]));
        chk("log_overflow", 64'(log_overflow), 64'(m_ovf));
        chk("core_meminput", 64'(core_meminput), 64'(m_ch[cfg_sel]));
    endtask

    // Advance model by one edge using the inputs currently driven, then compare
    task automatic step();
        int ph;
        bit pop;
        bit push;
        ph = m_phase();
        pop = (m_q.size() != 0) && log_ready;
        push = (ph == 1) && (((k - RESET_CYC) == 0) || (core_memoutput != m_prev));
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < LOG_DEPTH) m_q.push_back({CYC_W'(k - RESET_CYC), core_memoutput});
            else m_ovf = 1'b1;
        end
        if (ph == 1) m_prev = core_memoutput;
        if (cfg_we) m_ch[cfg_addr] = cfg_wdata;
        if (ph == 2 && restart) k = 0;
        else k++;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        core_memoutput = 32'h5;
        cfg_we = 1'b0;
        cfg_addr = 2'd0;
        cfg_wdata = 32'h0;
        cfg_sel = 2'd0;
        restart = 1'b0;
        log_ready = 1'b0;
        model_reset();

        cfg_tbl[0] = '{1'b1, 2'd2, 32'hDEAD,     2'd2, 32'hDEAD};
        cfg_tbl[1] = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0};
        cfg_tbl[2] = '{1'b1, 2'd0, 32'h1234,     2'd0, 32'h1234};
        cfg_tbl[3] = '{1'b1, 2'd3, 32'hCAFEF00D, 2'd3, 32'hCAFEF00D};
        cfg_tbl[4] = '{1'b0, 2'd0, 32'h0,        2'd2, 32'hDEAD};
        cfg_tbl[5] = '{1'b1, 2'd2, 32'h0,        2'd1, 32'h0};
        cfg_tbl[6] = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("rst_log_valid", 64'(log_valid), 64'd0);
        chk("rst_overflow", 64'(log_overflow), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_meminput", 64'(core_meminput), 64'd0);

        // Reset stretch: core held low for RESET_CYC edges after release
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= RESET_CYC + 1; i++) begin
            step();
            chk("stretch_core_rst_n", 64'(core_rst_n), 64'(i >= RESET_CYC));
        end

        // Constant memoutput logs once; change at run_cycle 7 logs again
        while (k < RESET_CYC + 7) step();
        core_memoutput = 32'h9;
        step();
        step();
        chk("log_first", 64'(log_data), {16'h0, 16'd0, 32'h5});
        log_ready = 1'b1;
        step();
        chk("log_second", 64'(log_data), {16'h0, 16'd7, 32'h9});
        step();
        chk("log_drained", 64'(log_valid), 64'd0);

        // Channel configuration table
        for (int i = 0; i < 7; i++) begin
            cfg_we = cfg_tbl[i].we;
            cfg_addr = cfg_tbl[i].addr;
            cfg_wdata = cfg_tbl[i].wdata;
            cfg_sel = cfg_tbl[i].sel;
            step();
            chk("cfg_table", 64'(core_meminput), 64'(cfg_tbl[i].exp_in));
        end
        cfg_we = 1'b0;

        // Run to completion
        while (k < RESET_CYC + MAX_CYC) step();
        chk("done_flag", 64'(done), 64'd1);
        chk("done_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("done_state", 64'(state), 64'd2);
        step();
        chk("done_stays", 64'(state), 64'd2);

        // Restart; fill FIFO exactly, then push+pop while full, then overflow
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_state", 64'(state), 64'd0);
        log_ready = 1'b0;
        while (k < RESET_CYC) step();
        for (int i = 0; i < LOG_DEPTH; i++) begin
            core_memoutput = 32'(100 + i);
            step();
        end
        chk("full_no_ovf", 64'(log_overflow), 64'd0);
        chk("full_head", 64'(log_data[CYC_W+DATA_W-1:DATA_W]), 64'd0);
        core_memoutput = 32'd108;
        log_ready = 1'b1;
        step();
        chk("pushpop_no_ovf", 64'(log_overflow), 64'd0);
        chk("pushpop_head", 64'(log_data[CYC_W+DATA_W-1:DATA_W]), 64'd1);
        core_memoutput = 32'd109;
        log_ready = 1'b0;
        step();
        chk("overflow_set", 64'(log_overflow), 64'd1);
        log_ready = 1'b1;
        for (int j = 1; j <= LOG_DEPTH; j++) begin
            chk("drain_order", 64'(log_data[CYC_W+DATA_W-1:DATA_W]), 64'(j));
            step();
        end
        chk("drain_empty", 64'(log_valid), 64'd0);

        // Randomized traffic across RUN, DONE and restarts
        for (int i = 0; i < 700; i++) begin
            core_memoutput = 32'($urandom_range(0, 3));
            log_ready = 1'($urandom_range(0, 1));
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_wdata = 32'($urandom);
            cfg_sel = 2'($urandom_range(0, 3));
            restart = ($urandom_range(0, 7) == 0);
            step();
        end
        cfg_we = 1'b0;
        restart = 1'b0;

        // Reset asserted mid-RUN
        for (int i = 0; i < 3 * (RESET_CYC + MAX_CYC) && m_phase() != 1; i++) begin
            restart = (m_phase() == 2);
            step();
        end
        restart = 1'b0;
        log_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            core_memoutput = 32'(200 + i);
            step();
        end
        chk("pre_rst_run", 64'(state), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_log_valid", 64'(log_valid), 64'd0);
        chk("midrst_overflow", 64'(log_overflow), 64'd0);
        chk("midrst_run_cycle", 64'(run_cycle), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < RESET_CYC + 10; i++) begin
            core_memoutput = 32'($urandom_range(0, 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
